// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 widths, fault causes, FSM states.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_ILLEGAL  = 2'b10,
        CAUSE_TIMEOUT  = 2'b11
    } cause_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Illegal encodings outrank misalignment.
    function automatic cause_e check_access(input logic ld, input logic st,
                                            input logic [2:0] f3, input logic [1:0] lo);
        if (ld == st || !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) || (st && f3[2]))
            return CAUSE_ILLEGAL;
        if ((f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00))
            return CAUSE_MISALIGN;
        return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-bus request/ack channel between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane steering for stores and alignment/extension for loads.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);
    logic [3:0][7:0] rbytes;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;

    assign rbytes = rdata;
    assign rbyte  = rbytes[addr_lo];
    assign rhalf  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata_ext = rdata;
        case (funct3)
            F3_B:    rdata_ext = {{24{rbyte[7]}}, rbyte};
            F3_BU:   rdata_ext = {24'd0, rbyte};
            F3_H:    rdata_ext = {{16{rhalf[15]}}, rhalf};
            F3_HU:   rdata_ext = {16'd0, rhalf};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one req/ack bus transaction per access, with fault detection and
// load alignment before writeback.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    load_store_unit_if.master mem,
    output logic        out_valid,
    output logic        out_we,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic [1:0]  out_cause
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e      state, nxt;
    cause_e      chk;
    logic        accept, tmo_hit;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [4:0]  rd_q;
    logic        load_q;
    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  a_f3;
    logic [1:0]  a_lo;
    logic [3:0]  a_be;
    logic [31:0] a_wd, a_ext;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready;
    assign chk      = check_access(in_load, in_store, in_funct3, in_addr[1:0]);
    assign tmo_hit  = (cnt == TMO_LAST);

    // One aligner serves both directions: live inputs while idle, latched access afterwards.
    assign a_f3 = (state == IDLE) ? in_funct3    : f3_q;
    assign a_lo = (state == IDLE) ? in_addr[1:0] : lo_q;

    lsu_align u_align (
        .funct3     (a_f3),
        .addr_lo    (a_lo),
        .wdata      (in_wdata),
        .rdata      (mem.rdata),
        .be         (a_be),
        .wdata_lane (a_wd),
        .rdata_ext  (a_ext)
    );

    assign mem.req   = req_q;
    assign mem.we    = we_q;
    assign mem.addr  = addr_q;
    assign mem.be    = be_q;
    assign mem.wdata = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = (chk == CAUSE_NONE) ? REQ : DONE;
            REQ:     if (mem.ack || tmo_hit) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {f3_q, lo_q, rd_q, load_q, cnt} <= '0;
            {req_q, we_q, addr_q, be_q, wdata_q} <= '0;
            {out_valid, out_we, out_rd, out_data, out_err, out_cause} <= '0;
        end else begin
            // Completion fields live for exactly one cycle.
            {out_valid, out_we, out_rd, out_data, out_err, out_cause} <= '0;
            if (accept) begin
                f3_q   <= in_funct3;
                lo_q   <= in_addr[1:0];
                rd_q   <= in_rd;
                load_q <= in_load;
                cnt    <= '0;
                if (chk == CAUSE_NONE) begin
                    req_q   <= 1'b1;
                    we_q    <= in_store;
                    addr_q  <= {in_addr[31:2], 2'b00};
                    be_q    <= a_be;
                    wdata_q <= a_wd;
                end else begin
                    out_valid <= 1'b1;
                    out_err   <= 1'b1;
                    out_cause <= chk;
                    out_rd    <= in_rd;
                end
            end else if (state == REQ) begin
                if (mem.ack || tmo_hit) begin
                    {req_q, we_q, addr_q, be_q, wdata_q} <= '0;
                    out_valid <= 1'b1;
                    out_rd    <= rd_q;
                end
                // Ack takes precedence over a coincident timeout.
                if (mem.ack) begin
                    out_we   <= load_q && (rd_q != 5'd0);
                    out_data <= load_q ? a_ext : 32'd0;
                end else if (tmo_hit) begin
                    out_err   <= 1'b1;
                    out_cause <= CAUSE_TIMEOUT;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT=4; cycle 0 is the accept cycle.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_load = 1'b0, in_store = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_addr = '0, in_wdata = '0;
    logic [4:0]  in_rd = '0;
    logic        in_ready;
    logic        out_valid, out_we, out_err;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic [1:0]  out_cause;

    int errs = 0;
    int checks = 0;

    load_store_unit_if mem_if ();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem(mem_if),
        .out_valid(out_valid), .out_we(out_we), .out_rd(out_rd), .out_data(out_data),
        .out_err(out_err), .out_cause(out_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          req_cnt;
        logic        stable;
        int          lat;
        logic        owe;
        logic [4:0]  ord;
        logic [31:0] odata;
        logic        oerr;
        logic [1:0]  ocause;
        logic        valid_after;
        logic        ready_after;
    } obs_t;

    // Runs one access from an idle negedge; ack_k = cycle of mem_ack (0 = never).
    task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [4:0] rd, input logic [31:0] rdata,
                              input int ack_k, output obs_t o);
        int cyc;
        in_valid = 1'b1; in_load = ld; in_store = st; in_funct3 = f3;
        in_addr = addr; in_wdata = wd; in_rd = rd;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        o.we = mem_if.we; o.addr = mem_if.addr; o.be = mem_if.be; o.wdata = mem_if.wdata;
        o.req_cnt = 0; o.stable = 1'b1;
        while (!out_valid && cyc < 40) begin
            if (mem_if.req) begin
                o.req_cnt++;
                if (mem_if.addr !== o.addr || mem_if.be !== o.be) o.stable = 1'b0;
            end
            mem_if.ack = (cyc == ack_k);
            mem_if.rdata = rdata;
            @(posedge clk); @(negedge clk);
            mem_if.ack = 1'b0;
            cyc++;
        end
        o.lat = cyc;
        o.owe = out_we; o.ord = out_rd; o.odata = out_data;
        o.oerr = out_err; o.ocause = out_cause;
        @(negedge clk);
        o.valid_after = out_valid;
        o.ready_after = in_ready;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (mem_if.req !== 1'b0) begin errs++; $display("FAIL reset_mem_req got %b exp 0", mem_if.req); end
        checks++; if ({out_valid, out_we, out_err, out_cause, out_rd, out_data} !== '0) begin
            errs++; $display("FAIL reset_outs got %b/%h exp 0", out_valid, out_data); end
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
    endtask

    task automatic test_lw();
        obs_t o;
        run_access(1, 0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 1, o);
        checks++; if (o.addr !== 32'h100) begin errs++; $display("FAIL lw_addr got %h exp 00000100", o.addr); end
        checks++; if (o.be !== 4'b1111) begin errs++; $display("FAIL lw_be got %b exp 1111", o.be); end
        checks++; if (o.we !== 1'b0) begin errs++; $display("FAIL lw_we got %b exp 0", o.we); end
        checks++; if (o.lat !== 2) begin errs++; $display("FAIL lw_latency got %0d exp 2", o.lat); end
        checks++; if (o.odata !== 32'hDEADBEEF) begin errs++; $display("FAIL lw_data got %h exp deadbeef", o.odata); end
        checks++; if (o.owe !== 1'b1 || o.ord !== 5'd5 || o.oerr !== 1'b0) begin
            errs++; $display("FAIL lw_wb got we=%b rd=%0d err=%b exp 1/5/0", o.owe, o.ord, o.oerr); end
        checks++; if (o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
            errs++; $display("FAIL lw_pulse got valid=%b ready=%b exp 0/1", o.valid_after, o.ready_after); end
    endtask

    task automatic test_lb_lbu();
        obs_t o;
        run_access(1, 0, 3'b000, 32'h103, 32'h0, 5'd3, 32'h80FF1234, 1, o);
        checks++; if (o.be !== 4'b1000) begin errs++; $display("FAIL lb_be got %b exp 1000", o.be); end
        checks++; if (o.odata !== 32'hFFFFFF80) begin errs++; $display("FAIL lb_data got %h exp ffffff80", o.odata); end
        run_access(1, 0, 3'b100, 32'h103, 32'h0, 5'd3, 32'h80FF1234, 1, o);
        checks++; if (o.odata !== 32'h00000080) begin errs++; $display("FAIL lbu_data got %h exp 00000080", o.odata); end
        run_access(1, 0, 3'b101, 32'h102, 32'h0, 5'd3, 32'h80FF1234, 1, o);
        checks++; if (o.be !== 4'b1100 || o.odata !== 32'h000080FF) begin
            errs++; $display("FAIL lhu got be=%b data=%h exp 1100/000080ff", o.be, o.odata); end
    endtask

    task automatic test_sh();
        obs_t o;
        run_access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 5'd7, 32'hFFFFFFFF, 1, o);
        checks++; if (o.we !== 1'b1 || o.addr !== 32'h200) begin errs++; $display("FAIL sh_we_addr got %b/%h exp 1/00000200", o.we, o.addr); end
        checks++; if (o.be !== 4'b1100) begin errs++; $display("FAIL sh_be got %b exp 1100", o.be); end
        checks++; if (o.wdata !== 32'hABCDABCD) begin errs++; $display("FAIL sh_wdata got %h exp abcdabcd", o.wdata); end
        checks++; if (o.owe !== 1'b0 || o.odata !== 32'h0 || o.lat !== 2) begin
            errs++; $display("FAIL sh_wb got we=%b data=%h lat=%0d exp 0/0/2", o.owe, o.odata, o.lat); end
        run_access(0, 1, 3'b000, 32'h201, 32'h000000A5, 5'd7, 32'h0, 1, o);
        checks++; if (o.be !== 4'b0010 || o.wdata !== 32'hA5A5A5A5) begin
            errs++; $display("FAIL sb got be=%b wdata=%h exp 0010/a5a5a5a5", o.be, o.wdata); end
    endtask

    task automatic test_faults();
        obs_t o;
        run_access(1, 0, 3'b010, 32'h101, 32'h0, 5'd9, 32'h0, 1, o);
        checks++; if (o.req_cnt !== 0 || o.lat !== 1) begin errs++; $display("FAIL misalign_timing got req=%0d lat=%0d exp 0/1", o.req_cnt, o.lat); end
        checks++; if (o.oerr !== 1'b1 || o.ocause !== 2'b01 || o.owe !== 1'b0) begin
            errs++; $display("FAIL misalign_cause got err=%b cause=%b we=%b exp 1/01/0", o.oerr, o.ocause, o.owe); end
        run_access(0, 1, 3'b100, 32'h200, 32'h0, 5'd9, 32'h0, 1, o);
        checks++; if (o.ocause !== 2'b10 || o.lat !== 1 || o.req_cnt !== 0) begin
            errs++; $display("FAIL illegal_store got cause=%b lat=%0d req=%0d exp 10/1/0", o.ocause, o.lat, o.req_cnt); end
        // Illegal kind on a misaligned address: illegal wins.
        run_access(1, 1, 3'b010, 32'h103, 32'h0, 5'd9, 32'h0, 1, o);
        checks++; if (o.ocause !== 2'b10) begin errs++; $display("FAIL illegal_priority got %b exp 10", o.ocause); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_access(1, 0, 3'b010, 32'h300, 32'h0, 5'd4, 32'h0, 0, o);
        checks++; if (o.req_cnt !== 4 || o.lat !== 5) begin errs++; $display("FAIL timeout_timing got req=%0d lat=%0d exp 4/5", o.req_cnt, o.lat); end
        checks++; if (o.oerr !== 1'b1 || o.ocause !== 2'b11 || o.odata !== 32'h0 || o.owe !== 1'b0) begin
            errs++; $display("FAIL timeout_cause got err=%b cause=%b data=%h exp 1/11/0", o.oerr, o.ocause, o.odata); end
        run_access(1, 0, 3'b001, 32'h302, 32'h0, 5'd4, 32'h80010000, 3, o);
        checks++; if (o.lat !== 4 || o.stable !== 1'b1 || o.be !== 4'b1100) begin
            errs++; $display("FAIL after_timeout got lat=%0d stable=%b be=%b exp 4/1/1100", o.lat, o.stable, o.be); end
        checks++; if (o.odata !== 32'hFFFF8001 || o.oerr !== 1'b0) begin
            errs++; $display("FAIL after_timeout_data got %h err=%b exp ffff8001/0", o.odata, o.oerr); end
        run_access(1, 0, 3'b010, 32'h304, 32'h0, 5'd4, 32'h12345678, 4, o);
        checks++; if (o.lat !== 5 || o.oerr !== 1'b0 || o.odata !== 32'h12345678) begin
            errs++; $display("FAIL ack_at_timeout got lat=%0d err=%b data=%h exp 5/0/12345678", o.lat, o.oerr, o.odata); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        run_access(1, 0, 3'b010, 32'h400, 32'h0, 5'd0, 32'hCAFEF00D, 1, o);
        checks++; if (o.owe !== 1'b0 || o.odata !== 32'hCAFEF00D) begin
            errs++; $display("FAIL rd0_load got we=%b data=%h exp 0/cafef00d", o.owe, o.odata); end
        run_access(0, 1, 3'b010, 32'h404, 32'h55AA55AA, 5'd1, 32'h0, 1, o);
        checks++; if (o.lat !== 2 || o.wdata !== 32'h55AA55AA || o.be !== 4'b1111) begin
            errs++; $display("FAIL b2b_sw got lat=%0d wdata=%h be=%b exp 2/55aa55aa/1111", o.lat, o.wdata, o.be); end
    endtask

    task automatic test_reset_mid_req();
        bit seen;
        in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_funct3 = 3'b010;
        in_addr = 32'h500; in_rd = 5'd2;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        checks++; if (mem_if.req !== 1'b1) begin errs++; $display("FAIL midreq_pre got %b exp 1", mem_if.req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_if.req !== 1'b0) begin errs++; $display("FAIL midreq_async_drop got %b exp 0", mem_if.req); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_if.ack = 1'b1; mem_if.rdata = 32'hBAD0BAD0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            mem_if.ack = 1'b0;
            if (out_valid || mem_if.req) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || in_ready !== 1'b1) begin
            errs++; $display("FAIL midreq_late_ack got activity=%b ready=%b exp 0/1", seen, in_ready); end
    endtask

    initial begin
        mem_if.ack = 1'b0;
        mem_if.rdata = '0;
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_faults();
        test_timeout();
        test_back_to_back();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
